// File: rtl/nios2_mem_test_pkg.sv
// Shared types and LFSR helper for the on-chip RAM self-test master.
package nios2_mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h1;

  // Galois right-shift step; an all-zero state never leaves zero, hence DEFAULT_SEED.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/nios2_lfsr32.sv
// 32-bit Galois LFSR with synchronous load (priority) and advance.
module nios2_lfsr32
  import nios2_mem_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/nios2_mem_test_master.sv
// Avalon-MM BIST master: writes an LFSR pattern over a word range, reads it back
// with fixed latency, and reports mismatch count and first failing address.
//
// state | meaning
// IDLE  | waiting for start; results of the last run held
// WRITE | issuing pattern writes, one per accepted beat
// READ  | issuing reads; each accepted read enters the valid pipe
// DRAIN | waiting for in-flight read data to be compared
// DONE  | one-cycle completion pulse, pass latched
module nios2_mem_test_master
  import nios2_mem_test_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic              read,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest
);

  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_BEAT  = {{ADDR_W{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, addr_q, cmp_addr_q, first_err_q;
  logic [ADDR_W:0]       count_q, remain_q, count_in;
  logic [31:0]           seed_q, seed_in, gen_seed, gen_state, chk_state;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  pass_q;
  logic [READ_LATENCY-1:0] pipe_q;
  logic                  start_go, wr_acc, rd_acc, last_beat;
  logic                  pipe_out, pipe_pending, mismatch, gen_load;

  assign count_in  = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
  assign seed_in   = (seed == 32'h0) ? DEFAULT_SEED : seed;
  assign start_go  = (state_q == ST_IDLE) && start;
  assign wr_acc    = (state_q == ST_WRITE) && !waitrequest;
  assign rd_acc    = (state_q == ST_READ) && !waitrequest;
  assign last_beat = (remain_q == ONE_BEAT);
  assign pipe_out  = pipe_q[READ_LATENCY-1];
  assign mismatch  = pipe_out && (readdata != chk_state);

  // Stages other than the output one; the output stage is consumed this cycle.
  always_comb begin
    pipe_pending = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      pipe_pending = pipe_pending | pipe_q[i];
    end
  end

  always_comb begin
    err_d = err_q;
    if (start_go) begin
      err_d = '0;
    end else if (mismatch && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  assign gen_load = start_go || (wr_acc && last_beat);
  assign gen_seed = start_go ? seed_in : seed_q;

  nios2_lfsr32 u_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (gen_load),
    .advance (wr_acc),
    .seed    (gen_seed),
    .state   (gen_state)
  );

  nios2_lfsr32 u_chk (
    .clk     (clk),
    .reset   (reset),
    .load    (start_go),
    .advance (pipe_out),
    .seed    (seed_in),
    .state   (chk_state)
  );

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    chipselect = 1'b0;
    address    = '0;
    writedata  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (count_in == '0) ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = addr_q;
        writedata  = gen_state;
        if (wr_acc && last_beat) state_d = ST_READ;
      end
      ST_READ: begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = addr_q;
        if (rd_acc && last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_pending) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      cmp_addr_q  <= '0;
      first_err_q <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      seed_q      <= '0;
      err_q       <= '0;
      pass_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      pipe_q[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end

      if (start_go) begin
        base_q   <= base_addr;
        addr_q   <= base_addr;
        count_q  <= count_in;
        remain_q <= count_in;
        seed_q   <= seed_in;
      end else if (wr_acc) begin
        // Rewind the beat counter and address for the read-back pass.
        if (last_beat) begin
          addr_q   <= base_q;
          remain_q <= count_q;
        end else begin
          addr_q   <= addr_q + 1'b1;
          remain_q <= remain_q - 1'b1;
        end
      end else if (rd_acc) begin
        addr_q   <= addr_q + 1'b1;
        remain_q <= remain_q - 1'b1;
      end

      if (start_go) begin
        cmp_addr_q  <= base_addr;
        first_err_q <= '0;
        pass_q      <= 1'b0;
      end else if (pipe_out) begin
        cmp_addr_q <= cmp_addr_q + 1'b1;
        if (mismatch && (err_q == '0)) first_err_q <= cmp_addr_q;
      end

      if (state_d == ST_DONE) pass_q <= (err_d == '0);
    end
  end

  assign byteenable     = 4'hF;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: doc/nios2_mem_test_master.md
Name: nios2_mem_test_master

Overview:
- Avalon-MM master (initiator) that drives the Nios II on-chip RAM slave port for built-in self-test.
- On start it writes a 32-bit LFSR pattern over a word range, reads it back, compares it and reports the error count and the first failing address.
- Sits beside the CPU on the same slave port, behind the interconnect arbiter or tied directly to the RAM.
- Assumes a fixed read latency with no readdatavalid, as the RAM provides.

Parameters:
- ADDR_W, 14, word address width of the slave.
- DATA_W, 32, data width; pattern logic is fixed at 32.
- READ_LATENCY, 1, cycles from an accepted read to valid readdata (1..4).
- ERR_W, 16, error counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a test when idle.
- base_addr  in  ADDR_W  first word address.
- word_count  in  ADDR_W+1  number of words; values above 2^ADDR_W are clamped.
- seed  in  32  LFSR seed; 0 is replaced by 1.
- busy  out  1  test in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  err_count==0; valid from done until the next start.
- err_count  out  ERR_W  mismatches, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- address  out  ADDR_W  Avalon word address.
- byteenable  out  4  constant 4'hF.
- chipselect  out  1  high during WRITE and READ issue.
- write  out  1  write request.
- read  out  1  read request.
- writedata  out  32  pattern word.
- readdata  in  32  slave read data.
- waitrequest  in  1  slave stall; tie 0 for a direct RAM connection.

Behaviour:
- Reset: all outputs 0 except byteenable=4'hF. FSM goes to IDLE, the read-valid pipe is cleared and outstanding reads are discarded. This holds for reset at any point mid-test.
- LFSR step (Galois): if s[0], s' = (s>>1)^32'h80200003, else s' = s>>1. Word i gets seed stepped i times.
- FSM states are IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: start latches base, count and seed and clears err_count, first_err_addr and pass.
  - count==0 goes to DONE; otherwise goes to WRITE.
  - busy=1 in every state except IDLE.
- WRITE:
  - chipselect=write=1, address=base+idx (mod 2^ADDR_W), writedata=gen LFSR.
  - idx and the LFSR advance only when waitrequest=0.
  - address, data and controls are held stable while stalled.
  - After the last accepted write: idx=0, gen LFSR reloaded from seed, go to READ.
- READ:
  - chipselect=read=1, address=base+idx.
  - On each accepted read, a 1 is pushed into a READ_LATENCY-deep valid shift register.
  - Back-to-back issue is allowed.
  - After the last accepted read, go to DRAIN.
- Compare, in any state:
  - When the pipe output is 1, compare readdata against the chk LFSR (separate, seeded from seed).
  - Then advance chk and cmp_idx.
  - On mismatch: err_count += 1, saturating at all-ones. If it is the first mismatch, first_err_addr = base+cmp_idx.
- DRAIN: wait until the pipe is empty, then go to DONE.
- DONE: done=1 for one cycle, pass=(err_count==0), go to IDLE. Results hold until the next start.
- start while busy is ignored.
- Timing with waitrequest=0, N>0 and start sampled at cycle 0:
  - writes occupy cycles 1..N.
  - reads occupy cycles N+1..2N.
  - done=1 at cycle 2N+READ_LATENCY+1.
- Timing with N=0: done at cycle 1, and no bus activity.
- Address wrap modulo 2^ADDR_W is silent.

Decomposition:
- Package nios2_mem_test_pkg:
  - state enum.
  - LFSR_POLY=32'h80200003.
  - function lfsr_next.
  - default seed constant 32'h1.
- Sub-module nios2_lfsr32 (load, advance, seed in, state out), instantiated twice: generator and checker.

Test Plan:
- Nominal run: base=0, N=4, seed=1, RAM model with latency 1, waitrequest=0.
  - Required writes: 0→0x00000001, 1→0x80200003, 2→0xC0300002, 3→0x60180001.
  - done at cycle 10, pass=1, err_count=0.
- Fault injection: same stimulus, with the RAM model flipping bit 0 of word 2 on read.
  - err_count=1, first_err_addr=2, pass=0.
- Wrap: base=0x3FFE, N=4.
  - Addresses issued are 3FFE, 3FFF, 0000, 0001 for both writes and reads; pass=1.
- Stalls: random waitrequest at 50% on the nominal run.
  - Outputs are held stable during each stall.
  - Identical data and results to the nominal run.
  - No duplicate or dropped beats.
- Reset mid-READ: assert reset for 1 cycle.
  - Next cycle busy=0 and all bus strobes are 0.
  - A new start with N=8 completes with pass=1.
- Zero length: N=0 gives done at cycle 1, pass=1, chipselect never asserted. start while busy is ignored.
